// File: rtl/mem_ring_stop.sv
// Requester-side ring stop in front of the memory controller: tags cache requests with
// a 4-bit id, injects them into empty ring slots and pulls matching responses back off.
module mem_ring_stop #(
    parameter int DATA_W  = 512,
    parameter int ADDR_W  = 36,
    parameter int NUM_IDS = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_write,
    output logic [ADDR_W-1:0] resp_addr,
    output logic [DATA_W-1:0] resp_data,
    input  logic [2:0]        packet_type_ring_in,
    input  logic [3:0]        id_ring_in,
    input  logic [ADDR_W-1:0] addr_ring_in,
    input  logic [DATA_W-1:0] data_ring_in,
    output logic [2:0]        packet_type_ring_out,
    output logic [3:0]        id_ring_out,
    output logic [ADDR_W-1:0] addr_ring_out,
    output logic [DATA_W-1:0] data_ring_out,
    output logic [4:0]        outstanding
);

    localparam int ID_W = 4;

    localparam logic [2:0] PT_EMPTY   = 3'b000;
    localparam logic [2:0] PT_WR_REQ  = 3'b001;
    localparam logic [2:0] PT_RD_REQ  = 3'b011;
    localparam logic [2:0] PT_WR_ACK  = 3'b101;
    localparam logic [2:0] PT_RD_DATA = 3'b110;

    logic [NUM_IDS-1:0] busy_q, busy_d;
    logic [ADDR_W-1:0]  addr_tab_q [NUM_IDS];

    logic              stg_valid_q, stg_valid_d;
    logic              stg_write_q, stg_write_d;
    logic [ADDR_W-1:0] stg_addr_q,  stg_addr_d;
    logic [DATA_W-1:0] stg_data_q,  stg_data_d;
    logic [ID_W-1:0]   stg_id_q,    stg_id_d;

    logic              resp_valid_q, resp_valid_d;
    logic              resp_write_q, resp_write_d;
    logic [ADDR_W-1:0] resp_addr_q,  resp_addr_d;
    logic [DATA_W-1:0] resp_data_q,  resp_data_d;

    logic [2:0]        ring_type_q, ring_type_d;
    logic [ID_W-1:0]   ring_id_q,   ring_id_d;
    logic [ADDR_W-1:0] ring_addr_q, ring_addr_d;
    logic [DATA_W-1:0] ring_data_q, ring_data_d;

    logic [4:0]        outstanding_q, outstanding_d;

    logic              free_found;
    logic [ID_W-1:0]   free_id;
    logic              accept, drain, is_resp, consume, inject;

    // Lowest-numbered free id wins; scanning downward leaves the smallest one last.
    always_comb begin
        free_found = 1'b0;
        free_id    = '0;
        for (int i = NUM_IDS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_found = 1'b1;
                free_id    = ID_W'(i);
            end
        end
    end

    assign req_ready = ~rst & ~stg_valid_q & free_found;
    assign accept    = req_valid & req_ready;
    assign drain     = resp_valid_q & resp_ready;
    assign is_resp   = (packet_type_ring_in == PT_WR_ACK) || (packet_type_ring_in == PT_RD_DATA);
    assign consume   = is_resp & busy_q[id_ring_in] & (~resp_valid_q | resp_ready);
    assign inject    = ((packet_type_ring_in == PT_EMPTY) | consume) & stg_valid_q;

    always_comb begin
        busy_d        = busy_q;
        stg_valid_d   = stg_valid_q;
        stg_write_d   = stg_write_q;
        stg_addr_d    = stg_addr_q;
        stg_data_d    = stg_data_q;
        stg_id_d      = stg_id_q;
        resp_valid_d  = resp_valid_q;
        resp_write_d  = resp_write_q;
        resp_addr_d   = resp_addr_q;
        resp_data_d   = resp_data_q;
        ring_type_d   = packet_type_ring_in;
        ring_id_d     = id_ring_in;
        ring_addr_d   = addr_ring_in;
        ring_data_d   = data_ring_in;
        outstanding_d = outstanding_q;

        if (inject) begin
            ring_type_d = stg_write_q ? PT_WR_REQ : PT_RD_REQ;
            ring_id_d   = stg_id_q;
            ring_addr_d = stg_addr_q;
            ring_data_d = stg_write_q ? stg_data_q : '0;
            stg_valid_d = 1'b0;
        end else if (consume) begin
            ring_type_d = PT_EMPTY;
            ring_id_d   = '0;
            ring_addr_d = '0;
            ring_data_d = '0;
        end

        if (consume) begin
            resp_valid_d       = 1'b1;
            resp_write_d       = (packet_type_ring_in == PT_WR_ACK);
            resp_addr_d        = addr_tab_q[id_ring_in];
            resp_data_d        = (packet_type_ring_in == PT_RD_DATA) ? data_ring_in : '0;
            busy_d[id_ring_in] = 1'b0;
        end else if (drain) begin
            resp_valid_d = 1'b0;
            resp_write_d = 1'b0;
            resp_addr_d  = '0;
            resp_data_d  = '0;
        end

        // Staging is empty whenever accept fires, so this never collides with inject.
        if (accept) begin
            stg_valid_d     = 1'b1;
            stg_write_d     = req_write;
            stg_addr_d      = req_addr;
            stg_data_d      = req_data;
            stg_id_d        = free_id;
            busy_d[free_id] = 1'b1;
        end

        case ({accept, consume})
            2'b10:   outstanding_d = outstanding_q + 5'd1;
            2'b01:   outstanding_d = outstanding_q - 5'd1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q        <= '0;
            stg_valid_q   <= 1'b0;
            stg_write_q   <= 1'b0;
            stg_addr_q    <= '0;
            stg_data_q    <= '0;
            stg_id_q      <= '0;
            resp_valid_q  <= 1'b0;
            resp_write_q  <= 1'b0;
            resp_addr_q   <= '0;
            resp_data_q   <= '0;
            ring_type_q   <= PT_EMPTY;
            ring_id_q     <= '0;
            ring_addr_q   <= '0;
            ring_data_q   <= '0;
            outstanding_q <= '0;
        end else begin
            busy_q        <= busy_d;
            stg_valid_q   <= stg_valid_d;
            stg_write_q   <= stg_write_d;
            stg_addr_q    <= stg_addr_d;
            stg_data_q    <= stg_data_d;
            stg_id_q      <= stg_id_d;
            resp_valid_q  <= resp_valid_d;
            resp_write_q  <= resp_write_d;
            resp_addr_q   <= resp_addr_d;
            resp_data_q   <= resp_data_d;
            ring_type_q   <= ring_type_d;
            ring_id_q     <= ring_id_d;
            ring_addr_q   <= ring_addr_d;
            ring_data_q   <= ring_data_d;
            outstanding_q <= outstanding_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_IDS; i++) begin
                addr_tab_q[i] <= '0;
            end
        end else if (accept) begin
            addr_tab_q[free_id] <= req_addr;
        end
    end

    assign resp_valid           = resp_valid_q;
    assign resp_write           = resp_write_q;
    assign resp_addr            = resp_addr_q;
    assign resp_data            = resp_data_q;
    assign packet_type_ring_out = ring_type_q;
    assign id_ring_out          = ring_id_q;
    assign addr_ring_out        = ring_addr_q;
    assign data_ring_out        = ring_data_q;
    assign outstanding          = outstanding_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (outstanding_q <= 5'd16)
                else $error("outstanding count above 16");
            assert (!(consume && !accept && outstanding_q == 5'd0))
                else $error("outstanding count underflow");
            assert (!(accept && !consume && outstanding_q == 5'd16))
                else $error("outstanding count overflow");
        end
    end
`endif

endmodule

// File: tb/tb_mem_ring_stop.sv
// Directed bench for mem_ring_stop: a transaction-level model predicts every output each
// cycle, and literal expectations at key points pin that model down.
module tb_mem_ring_stop;

    localparam int DW = 512;
    localparam int AW = 36;
    localparam int NI = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          resp_valid, resp_ready, resp_write;
    logic [AW-1:0] resp_addr;
    logic [DW-1:0] resp_data;
    logic [2:0]    pt_in, pt_out;
    logic [3:0]    id_in, id_out;
    logic [AW-1:0] addr_in, addr_out;
    logic [DW-1:0] data_in, data_out;
    logic [4:0]    outstanding;

    always #5 clk = ~clk;

    mem_ring_stop dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
        .resp_addr(resp_addr), .resp_data(resp_data),
        .packet_type_ring_in(pt_in), .id_ring_in(id_in),
        .addr_ring_in(addr_in), .data_ring_in(data_in),
        .packet_type_ring_out(pt_out), .id_ring_out(id_out),
        .addr_ring_out(addr_out), .data_ring_out(data_out),
        .outstanding(outstanding)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit live     = 0;

    task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Transaction-level model: id pool, staging slot, response slot, expected ring slot.
    bit            m_busy [NI];
    logic [AW-1:0] m_addr [NI];
    bit            m_stg_v, m_stg_w;
    logic [AW-1:0] m_stg_a;
    logic [DW-1:0] m_stg_d;
    int            m_stg_id;
    bit            m_rv, m_rw;
    logic [AW-1:0] m_ra;
    logic [DW-1:0] m_rd;
    logic [2:0]    m_ot;
    logic [3:0]    m_oid;
    logic [AW-1:0] m_oa;
    logic [DW-1:0] m_od;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < NI; i++) if (m_busy[i]) c++;
        return c;
    endfunction

    function automatic int m_lowest_free();
        for (int i = 0; i < NI; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    function automatic bit m_ready();
        return !rst && !m_stg_v && (m_lowest_free() >= 0);
    endfunction

    int  mf_id;
    bit  mf_acc, mf_cons, mf_drain;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NI; i++) begin
                m_busy[i] = 0;
                m_addr[i] = '0;
            end
            m_stg_v = 0; m_stg_w = 0; m_stg_a = '0; m_stg_d = '0; m_stg_id = 0;
            m_rv = 0; m_rw = 0; m_ra = '0; m_rd = '0;
            m_ot = 3'b000; m_oid = '0; m_oa = '0; m_od = '0;
        end else begin
            mf_id    = m_lowest_free();
            mf_acc   = req_valid && !m_stg_v && (mf_id >= 0);
            mf_cons  = (pt_in == 3'b101 || pt_in == 3'b110) && m_busy[id_in] && (!m_rv || resp_ready);
            mf_drain = m_rv && resp_ready;
            if ((pt_in == 3'b000 || mf_cons) && m_stg_v) begin
                m_ot  = m_stg_w ? 3'b001 : 3'b011;
                m_oid = 4'(m_stg_id);
                m_oa  = m_stg_a;
                m_od  = m_stg_w ? m_stg_d : '0;
                m_stg_v = 0;
            end else if (mf_cons) begin
                m_ot = 3'b000; m_oid = '0; m_oa = '0; m_od = '0;
            end else begin
                m_ot = pt_in; m_oid = id_in; m_oa = addr_in; m_od = data_in;
            end
            if (mf_cons) begin
                m_rv = 1;
                m_rw = (pt_in == 3'b101);
                m_ra = m_addr[id_in];
                m_rd = (pt_in == 3'b110) ? data_in : '0;
                m_busy[id_in] = 0;
            end else if (mf_drain) begin
                m_rv = 0;
            end
            if (mf_acc) begin
                m_busy[mf_id] = 1;
                m_addr[mf_id] = req_addr;
                m_stg_v = 1; m_stg_w = req_write; m_stg_a = req_addr;
                m_stg_d = req_data; m_stg_id = mf_id;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && live) begin
            chk("ring_out", {pt_out, id_out, addr_out, data_out}, {m_ot, m_oid, m_oa, m_od});
            chk("resp_valid", resp_valid, m_rv);
            if (m_rv) chk("resp_fields", {resp_write, resp_addr, resp_data}, {m_rw, m_ra, m_rd});
            chk("outstanding", outstanding, m_count());
            chk("req_ready", req_ready, m_ready());
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic rin(input logic [2:0] t, input logic [3:0] id, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
        pt_in = t; id_in = id; addr_in = a; data_in = d;
    endtask

    task automatic rin_empty();
        rin(3'b000, 4'd0, '0, '0);
    endtask

    task automatic send_req(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit acc = 0;
        req_valid = 1; req_write = w; req_addr = a; req_data = d;
        for (int k = 0; k < 40 && !acc; k++) begin
            acc = m_ready();
            tick();
        end
        req_valid = 0;
        if (!acc) begin
            n_checks++;
            $display("FAIL req_accept_timeout: addr %0h not accepted within 40 cycles", a);
        end
    endtask

    logic [DW-1:0] RD1, RD2, RD3, WD1, WD2, WD3;

    initial begin
        RD1 = {64{8'hAB}};
        RD2 = {16{32'h7777_0007}};
        RD3 = {16{32'h3333_C0DE}};
        WD1 = {16{32'hDEAD_BEEF}};
        WD2 = {16{32'h0123_4567}};
        WD3 = {16{32'hCAFE_F00D}};
        rst = 1; req_valid = 0; req_write = 0; req_addr = '0; req_data = '0;
        resp_ready = 1;
        rin_empty();

        #2;
        chk("reset_ring_type", pt_out, 3'b000);
        chk("reset_outstanding", outstanding, 5'd0);
        chk("reset_req_ready", req_ready, 1'b0);
        chk("reset_resp_valid", resp_valid, 1'b0);
        repeat (2) @(posedge clk);
        #3;
        rst = 0;
        live = 1;

        // single read
        send_req(0, 36'h123, '0);
        tick();
        chk("rd_inject", {pt_out, id_out, addr_out, data_out}, {3'b011, 4'd0, 36'h123, 512'd0});
        chk("rd_outstanding", outstanding, 5'd1);
        rin(3'b110, 4'd0, '0, RD1);
        tick();
        rin_empty();
        chk("rd_resp", {resp_valid, resp_write, resp_addr, resp_data}, {1'b1, 1'b0, 36'h123, RD1});
        chk("rd_consumed_slot", pt_out, 3'b000);
        chk("rd_outstanding_after", outstanding, 5'd0);
        tick();
        chk("rd_resp_drained", resp_valid, 1'b0);

        // single write
        send_req(1, 36'h40, WD1);
        tick();
        chk("wr_inject", {pt_out, id_out, addr_out, data_out}, {3'b001, 4'd0, 36'h40, WD1});
        rin(3'b101, 4'd0, '0, '0);
        tick();
        rin_empty();
        chk("wr_ack", {resp_valid, resp_write, resp_addr, resp_data}, {1'b1, 1'b1, 36'h40, 512'd0});
        tick();

        // busy ring: staged write waits for the first empty slot
        rin(3'b011, 4'd5, 36'h55, '0);
        send_req(1, 36'h88, WD2);
        for (int i = 0; i < 10; i++) begin
            rin(3'b011, 4'(5 + (i % 2)), 36'h55, '0);
            tick();
            chk("busy_pass", {pt_out, id_out}, {3'b011, 4'(5 + (i % 2))});
        end
        rin_empty();
        tick();
        chk("busy_inject", {pt_out, id_out, addr_out}, {3'b001, 4'd0, 36'h88});
        rin(3'b101, 4'd0, '0, '0);
        tick();
        rin_empty();
        tick();

        // fill all 16 ids
        for (int i = 0; i < 16; i++) begin
            send_req(0, 36'h1000 + AW'(i), '0);
            tick();
            chk("fill_id", {pt_out, id_out}, {3'b011, 4'(i)});
        end
        chk("full_outstanding", outstanding, 5'd16);
        chk("full_req_ready", req_ready, 1'b0);
        rin(3'b110, 4'd7, '0, RD2);
        tick();
        rin_empty();
        chk("refree_req_ready", req_ready, 1'b1);
        chk("refree_resp", {resp_addr, resp_data}, {36'h1007, RD2});
        send_req(0, 36'h2000, '0);
        tick();
        chk("realloc_id7", {pt_out, id_out, addr_out}, {3'b011, 4'd7, 36'h2000});
        chk("realloc_outstanding", outstanding, 5'd16);

        // backpressure
        resp_ready = 0;
        rin(3'b110, 4'd0, '0, RD1);
        tick();
        chk("bp_held", {resp_valid, resp_addr}, {1'b1, 36'h1000});
        rin(3'b110, 4'd3, '0, RD3);
        tick();
        rin_empty();
        chk("bp_passthru", {pt_out, id_out, data_out}, {3'b110, 4'd3, RD3});
        chk("bp_resp_kept", resp_addr, 36'h1000);
        chk("bp_outstanding", outstanding, 5'd15);
        resp_ready = 1;
        tick();
        rin(3'b110, 4'd3, '0, RD3);
        tick();
        rin_empty();
        chk("bp_replay", {resp_valid, resp_addr, resp_data, pt_out}, {1'b1, 36'h1003, RD3, 3'b000});
        chk("bp_outstanding_after", outstanding, 5'd14);

        // reset between tests, asynchronously
        #1 rst = 1;
        #1 chk("rst1_outstanding", outstanding, 5'd0);
        @(posedge clk);
        #3 rst = 0;

        // consume-and-inject in the same slot
        for (int i = 0; i < 4; i++) begin
            send_req(0, 36'h300 + AW'(i), '0);
            tick();
        end
        rin(3'b011, 4'd9, 36'h99, '0);
        send_req(1, 36'h340, WD3);
        tick();
        rin(3'b110, 4'd2, '0, RD1);
        tick();
        rin_empty();
        chk("ci_slot", {pt_out, id_out, addr_out, data_out}, {3'b001, 4'd4, 36'h340, WD3});
        chk("ci_resp", {resp_valid, resp_addr}, {1'b1, 36'h302});
        chk("ci_outstanding", outstanding, 5'd4);

        // async reset mid-run, checked between clock edges
        #1 rst = 1;
        #1;
        chk("arst_ring", {pt_out, id_out, addr_out, data_out}, {3'b000, 4'd0, 36'd0, 512'd0});
        chk("arst_outstanding", outstanding, 5'd0);
        chk("arst_resp_valid", resp_valid, 1'b0);
        @(posedge clk);
        #3 rst = 0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_ring_stop.md
Name: mem_ring_stop

Overview:
- Requester-side ring stop sitting directly upstream of the memory controller on the circular request/response packet ring.
- Accepts line read and line write requests from the cache, assigns each a 4-bit transaction id, and injects it into an empty ring slot.
- Removes matching read-data and write-ack responses from the ring and returns them to the cache.
- Tracks up to 16 outstanding transactions.

Parameters:
DATA_W, 512, ring/cache line data width in bits
ADDR_W, 36, line address width carried on the ring
NUM_IDS, 16, outstanding transaction limit; fixed to 2^4 by ring id width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  cache request present
req_ready  out  1  stop accepts request this cycle
req_write  in  1  1 = line write, 0 = line read
req_addr  in  ADDR_W  line address
req_data  in  DATA_W  write data (ignored for reads)
resp_valid  out  1  response presented to cache
resp_ready  in  1  cache accepts response
resp_write  out  1  1 = write ack, 0 = read data
resp_addr  out  ADDR_W  address of completed transaction
resp_data  out  DATA_W  read data (0 for write ack)
packet_type_ring_in  in  3  incoming slot type
id_ring_in  in  4  incoming slot id
addr_ring_in  in  ADDR_W  incoming slot address
data_ring_in  in  DATA_W  incoming slot data
packet_type_ring_out  out  3  outgoing slot type (to controller)
id_ring_out  out  4  outgoing slot id
addr_ring_out  out  ADDR_W  outgoing slot address
data_ring_out  out  DATA_W  outgoing slot data
outstanding  out  5  count of allocated ids, 0..16

Behaviour:
- Packet types:
  - 000 empty slot
  - 001 write request
  - 011 read request
  - 101 write ack
  - 110 read data
  - any other value is passed through untouched.
- Reset (async): all ring outputs 0 (empty slot), resp_valid=0, resp_* = 0, outstanding=0, req_ready=0 while rst high, id table all free, staging register empty.
- Ring path is one register stage: ring_out at cycle N+1 reflects the decision made on ring_in at cycle N. Every cycle exactly one slot is emitted.
- Id table: per id a busy bit, write flag and address. Allocation picks the lowest-numbered free id.
- req_ready = staging register empty AND at least one free id.
- On req_valid & req_ready:
  - latch {write, addr, data, allocated id} into staging;
  - mark the id busy;
  - outstanding +1.
- Slot decision, priority order each cycle:
  1. Consume: ring_in type is 101 or 110, id busy in table, and the response register is empty or being drained this cycle (resp_ready & resp_valid).
     - Load the response register: resp_write = (type==101); resp_addr from the table; resp_data = data_ring_in for 110, 0 for 101.
     - Free the id; outstanding -1.
     - The slot becomes empty, so rule 2 may inject into it in the same cycle.
  2. Inject: slot is empty (type 000, or just consumed) and staging is full.
     - Emit type 001 (write) or 011 (read), the staged id, addr and data (data 0 for reads).
     - Clear staging.
  3. Otherwise pass ring_in through unchanged.
- Response type/id mismatch: a response whose id is not busy is passed through, never consumed.
- Backpressure: if the response register is held (resp_valid & ~resp_ready), a matching response passes through and is retried on a later revolution. No response is ever dropped.
- resp_valid stays high until resp_ready. The response register is one entry, with same-cycle drain-and-refill allowed.
- Simultaneous accept and consume in one cycle: outstanding is unchanged, and the freed id is not reallocated until the next cycle.
- Full: with 16 ids busy, req_ready=0. It reasserts the cycle after the first consume.
- outstanding never wraps. Reaching 17 or going below 0 is a design error and is flagged by an assertion in simulation.
- Reset mid-operation clears all state immediately; in-flight ring packets are discarded by the ring owner.

Test Plan:
- Single read: req read addr 0x123 on an empty ring → next cycle type 011, id 0, addr 0x123 out. Drive type 110, id 0, data 0xAB.. in → resp_valid with resp_write=0, resp_addr 0x123, data 0xAB..; outstanding 1→0.
- Single write: req write addr 0x40, data D → type 001, id 0, data D out. Inject 101 id 0 → resp_write=1, resp_addr 0x40, resp_data 0.
- Busy ring: incoming slots type 011, ids 5/6 for 10 cycles while staging is full → slots pass through unchanged; injection happens on the first 000 slot.
- Fill: 16 back-to-back requests → ids 0..15 issued, outstanding=16, req_ready=0. Return id 7 → req_ready=1 the next cycle, and the next request gets id 7.
- Backpressure: resp_ready=0 with one response held; second matching response id 3 arrives → passes through unconsumed, id 3 still busy. Raise resp_ready and replay id 3 → consumed.
- Consume-and-inject: response id 2 arrives while staging holds a write with id 4 → same slot out = type 001, id 4. Async rst asserted mid-run → ring out 000, outstanding 0 without waiting for clk.
